// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared types and constants for the tile-merge game controller
package game_pkg;

  typedef logic [3:0] cell_t;
  typedef cell_t [0:3] line_t;
  typedef line_t [0:3] matrix_t;

  localparam int DIR_UP    = 0;
  localparam int DIR_DOWN  = 1;
  localparam int DIR_LEFT  = 2;
  localparam int DIR_RIGHT = 3;

  localparam logic [1:0] ST_PLAY = 2'd0;
  localparam logic [1:0] ST_WON  = 2'd1;
  localparam logic [1:0] ST_LOST = 2'd2;

  localparam cell_t GOAL_DEFAULT = 4'd11;

  typedef enum logic [2:0] {
    GS_INIT, GS_IDLE, GS_MOVE, GS_SPAWN, GS_CHECK, GS_WON, GS_LOST
  } game_state_e;

  // Element k of line i, ordered toward the move direction; returns {row, col}.
  function automatic logic [3:0] cell_pos(input logic [3:0] d, input logic [1:0] i,
                                          input logic [1:0] k);
    if (d[DIR_LEFT])       return {i, k};
    else if (d[DIR_RIGHT]) return {i, 2'd3 - k};
    else if (d[DIR_UP])    return {k, i};
    else                   return {2'd3 - k, i};
  endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// rtl/move_sequencer_if.sv - control and board signals between game logic and its environment
interface move_sequencer_if #(
  parameter int SCORE_W = 12
);
  import game_pkg::*;

  logic               restart;
  logic [3:0]         dir;
  logic [3:0]         goal;
  logic               load_en;
  matrix_t            load_matrix;
  matrix_t            gmatrix;
  logic [SCORE_W-1:0] score;
  logic [1:0]         draw_state;
  logic               busy;

  modport master (
    output restart, dir, goal, load_en, load_matrix,
    input  gmatrix, score, draw_state, busy
  );

  modport slave (
    input  restart, dir, goal, load_en, load_matrix,
    output gmatrix, score, draw_state, busy
  );

endinterface

// File: rtl/line_merge.sv
// rtl/line_merge.sv - combinational compress-and-merge of one four-cell line toward element 0
module line_merge
  import game_pkg::*;
#(
  parameter int SCORE_W = 12
) (
  input  line_t            line_i,
  output line_t            line_o,
  output logic [SCORE_W:0] points_o,
  output logic             changed_o
);

  localparam int PMAX = 2 ** (SCORE_W + 1) - 1;

  cell_t       ext [0:4];
  line_t       res;
  logic [16:0] pts;
  logic [1:0]  n;
  logic [1:0]  j;
  logic        skip;

  always_comb begin
    for (int i = 0; i < 5; i++) ext[i] = 4'd0;
    n = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (line_i[i] != 4'd0) begin
        ext[n] = line_i[i];
        n      = n + 2'd1;
      end
    end

    // A merged pair consumes both inputs, so its result never meets the next cell.
    res  = '0;
    pts  = '0;
    j    = 2'd0;
    skip = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (skip) begin
        skip = 1'b0;
      end else if (ext[i] != 4'd0) begin
        if (ext[i] == ext[i+1] && ext[i] != 4'hF) begin
          res[j] = ext[i] + 4'd1;
          pts    = pts + (17'd1 << (ext[i] + 4'd1));
          skip   = 1'b1;
        end else begin
          res[j] = ext[i];
        end
        j = j + 2'd1;
      end
    end
  end

  assign line_o    = res;
  assign points_o  = (pts > 17'(PMAX)) ? '1 : pts[SCORE_W:0];
  assign changed_o = (res != line_i);

endmodule

// File: rtl/move_sequencer.sv
// rtl/move_sequencer.sv - game FSM owning the 4x4 board and score: move, spawn, win/lose check
module move_sequencer
  import game_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          SCORE_W   = 12
) (
  input logic             clk,
  input logic             reset,
  move_sequencer_if.slave bus
);

  localparam logic [2:0] S_INIT  = 3'(GS_INIT);
  localparam logic [2:0] S_IDLE  = 3'(GS_IDLE);
  localparam logic [2:0] S_MOVE  = 3'(GS_MOVE);
  localparam logic [2:0] S_SPAWN = 3'(GS_SPAWN);
  localparam logic [2:0] S_CHECK = 3'(GS_CHECK);
  localparam logic [2:0] S_WON   = 3'(GS_WON);
  localparam logic [2:0] S_LOST  = 3'(GS_LOST);

  logic [2:0]         state_q, state_d;
  matrix_t            gmat_q, gmat_d;
  logic [SCORE_W-1:0] score_q, score_d;
  logic [1:0]         draw_q, draw_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [1:0]         line_q, line_d;
  logic               changed_q, changed_d;
  logic [3:0]         dir_q, dir_d;
  logic               spawn_first_q, spawn_first_d;
  logic               spawn_more_q, spawn_more_d;
  logic [3:0]         spawn_idx_q, spawn_idx_d;
  logic [3:0]         spawn_cnt_q, spawn_cnt_d;
  cell_t              spawn_val_q, spawn_val_d;

  line_t              lm_in, lm_out;
  logic [SCORE_W:0]   lm_pts;
  logic               lm_changed;
  logic [3:0]         rpos, wpos;
  logic [SCORE_W+1:0] score_sum;
  logic [SCORE_W-1:0] score_sat;
  logic [3:0]         cur_idx, probe_n;
  cell_t              cur_val, eff_goal;
  logic               cur_empty, any_goal, any_empty, any_pair;

  line_merge #(.SCORE_W(SCORE_W)) u_merge (
    .line_i    (lm_in),
    .line_o    (lm_out),
    .points_o  (lm_pts),
    .changed_o (lm_changed)
  );

  always_comb begin
    lm_in = '0;
    rpos  = '0;
    for (int k = 0; k < 4; k++) begin
      rpos     = cell_pos(dir_q, line_q, 2'(k));
      lm_in[k] = gmat_q[rpos[3:2]][rpos[1:0]];
    end
  end

  assign score_sum = {2'b00, score_q} + {1'b0, lm_pts};
  assign score_sat = (|score_sum[SCORE_W+1:SCORE_W]) ? '1 : score_sum[SCORE_W-1:0];

  // The first probe of a spawn takes its start cell and value straight from the LFSR.
  assign cur_idx   = spawn_first_q ? lfsr_q[3:0] : spawn_idx_q;
  assign cur_val   = spawn_first_q ? ((lfsr_q[6:4] == 3'd0) ? 4'd2 : 4'd1) : spawn_val_q;
  assign probe_n   = spawn_first_q ? 4'd0 : spawn_cnt_q;
  assign cur_empty = (gmat_q[cur_idx[3:2]][cur_idx[1:0]] == 4'd0);
  assign eff_goal  = (bus.goal == 4'd0) ? GOAL_DEFAULT : bus.goal;

  always_comb begin
    any_goal  = 1'b0;
    any_empty = 1'b0;
    any_pair  = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (gmat_q[r][c] == eff_goal) any_goal = 1'b1;
        if (gmat_q[r][c] == 4'd0)     any_empty = 1'b1;
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 3; c++)
        if (gmat_q[r][c] == gmat_q[r][c+1]) any_pair = 1'b1;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 4; c++)
        if (gmat_q[r][c] == gmat_q[r+1][c]) any_pair = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    gmat_d        = gmat_q;
    score_d       = score_q;
    draw_d        = draw_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    line_d        = line_q;
    changed_d     = changed_q;
    dir_d         = dir_q;
    spawn_first_d = spawn_first_q;
    spawn_more_d  = spawn_more_q;
    spawn_idx_d   = spawn_idx_q;
    spawn_cnt_d   = spawn_cnt_q;
    spawn_val_d   = spawn_val_q;
    wpos          = '0;

    case (state_q)
      S_INIT: begin
        gmat_d        = '0;
        score_d       = '0;
        spawn_first_d = 1'b1;
        spawn_more_d  = 1'b1;
        state_d       = S_SPAWN;
      end
      S_IDLE, S_WON, S_LOST: begin
        if (bus.load_en) begin
          gmat_d  = bus.load_matrix;
          draw_d  = ST_PLAY;
          state_d = S_CHECK;
        end else if (state_q == S_IDLE && $onehot(bus.dir)) begin
          state_d   = S_MOVE;
          line_d    = 2'd0;
          changed_d = 1'b0;
          dir_d     = bus.dir;
        end
      end
      S_MOVE: begin
        for (int k = 0; k < 4; k++) begin
          wpos = cell_pos(dir_q, line_q, 2'(k));
          gmat_d[wpos[3:2]][wpos[1:0]] = lm_out[k];
        end
        score_d   = score_sat;
        changed_d = changed_q | lm_changed;
        line_d    = line_q + 2'd1;
        if (line_q == 2'd3) begin
          spawn_first_d = 1'b1;
          spawn_more_d  = 1'b0;
          state_d       = (changed_q | lm_changed) ? S_SPAWN : S_CHECK;
        end
      end
      S_SPAWN: begin
        spawn_first_d = 1'b0;
        spawn_idx_d   = cur_idx + 4'd1;
        spawn_val_d   = cur_val;
        spawn_cnt_d   = probe_n + 4'd1;
        if (cur_empty || probe_n == 4'd15) begin
          if (cur_empty) gmat_d[cur_idx[3:2]][cur_idx[1:0]] = cur_val;
          if (spawn_more_q) begin
            spawn_more_d  = 1'b0;
            spawn_first_d = 1'b1;
          end else begin
            state_d = S_CHECK;
          end
        end
      end
      S_CHECK: begin
        if (any_goal) begin
          draw_d  = ST_WON;
          state_d = S_WON;
        end else if (!any_empty && !any_pair) begin
          draw_d  = ST_LOST;
          state_d = S_LOST;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_INIT;
    endcase

    if (bus.restart) begin
      state_d = S_INIT;
      draw_d  = ST_PLAY;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_INIT;
      gmat_q        <= '0;
      score_q       <= '0;
      draw_q        <= ST_PLAY;
      lfsr_q        <= LFSR_SEED;
      line_q        <= 2'd0;
      changed_q     <= 1'b0;
      dir_q         <= 4'b0100;
      spawn_first_q <= 1'b1;
      spawn_more_q  <= 1'b0;
      spawn_idx_q   <= 4'd0;
      spawn_cnt_q   <= 4'd0;
      spawn_val_q   <= 4'd1;
    end else begin
      state_q       <= state_d;
      gmat_q        <= gmat_d;
      score_q       <= score_d;
      draw_q        <= draw_d;
      lfsr_q        <= lfsr_d;
      line_q        <= line_d;
      changed_q     <= changed_d;
      dir_q         <= dir_d;
      spawn_first_q <= spawn_first_d;
      spawn_more_q  <= spawn_more_d;
      spawn_idx_q   <= spawn_idx_d;
      spawn_cnt_q   <= spawn_cnt_d;
      spawn_val_q   <= spawn_val_d;
    end
  end

  assign bus.gmatrix    = gmat_q;
  assign bus.score      = score_q;
  assign bus.draw_state = draw_q;
  assign bus.busy       = !(state_q == S_IDLE || state_q == S_WON || state_q == S_LOST);

endmodule

// File: tb/tb_move_sequencer.sv
// tb/tb_move_sequencer.sv - directed vector bench for the move sequencer
module tb_move_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  move_sequencer_if #(.SCORE_W(12)) bus ();

  move_sequencer #(.LFSR_SEED(16'hACE1), .SCORE_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [63:0] load_m;
    logic [3:0]  dir;
    logic [63:0] exp_m;
    logic        spawn;
    int          pts;
  } vec_t;

  vec_t vecs [12];
  int   n_pass  = 0;
  int   n_total = 0;
  int   score_exp;
  int   n;
  logic [63:0] snap;

  localparam logic [3:0] UP = 4'b0001, DOWN = 4'b0010, LEFT = 4'b0100, RIGHT = 4'b1000;

  task automatic check(input string name, input logic ok, input logic [63:0] act,
                       input logic [63:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [3:0] opp(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Board equals exp except for the spawned tile: one formerly-empty cell now holding 1 or 2.
  function automatic logic spawn_ok(input logic [63:0] got, input logic [63:0] exp,
                                    input logic sp);
    int nd;
    logic ok;
    logic [3:0] g, e;
    nd = 0;
    ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      g = got[c*4 +: 4];
      e = exp[c*4 +: 4];
      if (g != e) begin
        nd++;
        if (e != 4'd0 || g == 4'd0 || g > 4'd2) ok = 1'b0;
      end
    end
    return ok && (nd == (sp ? 1 : 0));
  endfunction

  function automatic logic fresh_ok(input logic [63:0] m);
    int nz;
    logic ok;
    logic [3:0] v;
    nz = 0;
    ok = 1'b1;
    for (int c = 0; c < 16; c++) begin
      v = m[c*4 +: 4];
      if (v != 4'd0) begin
        nz++;
        if (v > 4'd2) ok = 1'b0;
      end
    end
    return ok && nz == 2;
  endfunction

  task automatic wait_busy(input int max, input logic [3:0] intf, output int cnt);
    cnt = 0;
    while (bus.busy && cnt < max) begin
      cnt++;
      bus.dir = (cnt == 2) ? intf : 4'd0;
      @(negedge clk);
    end
    bus.dir = 4'd0;
  endtask

  task automatic do_load(input logic [63:0] m);
    bus.load_matrix = m;
    bus.load_en     = 1'b1;
    @(negedge clk);
    bus.load_en     = 1'b0;
  endtask

  initial begin
    vecs[0]  = '{64'h1122_0000_0000_0000, LEFT,  64'h2300_0000_0000_0000, 1'b1, 12};
    vecs[1]  = '{64'h1111_0000_0000_0000, LEFT,  64'h2200_0000_0000_0000, 1'b1, 8};
    vecs[2]  = '{64'h1000_0000_0000_0000, LEFT,  64'h1000_0000_0000_0000, 1'b0, 0};
    vecs[3]  = '{64'h1122_0000_0000_0000, RIGHT, 64'h0023_0000_0000_0000, 1'b1, 12};
    vecs[4]  = '{64'h1000_1000_0000_0000, UP,    64'h2000_0000_0000_0000, 1'b1, 4};
    vecs[5]  = '{64'h0030_0000_0030_0000, DOWN,  64'h0000_0000_0000_0040, 1'b1, 16};
    vecs[6]  = '{64'hFF00_0000_0000_0000, LEFT,  64'hFF00_0000_0000_0000, 1'b0, 0};
    vecs[7]  = '{64'h2021_0000_0000_0000, LEFT,  64'h3100_0000_0000_0000, 1'b1, 8};
    vecs[8]  = '{64'h1001_0000_2220_0000, LEFT,  64'h2000_0000_3200_0000, 1'b1, 12};
    vecs[9]  = '{64'h0000_0000_0000_0011, UP,    64'h0011_0000_0000_0000, 1'b1, 0};
    vecs[10] = '{64'hEEEE_0000_0000_0000, LEFT,  64'hFF00_0000_0000_0000, 1'b1, 65536};
    vecs[11] = '{64'h1000_0000_0000_0000, DOWN,  64'h0000_0000_0000_1000, 1'b1, 0};

    reset = 1'b0;
    bus.restart = 1'b0;
    bus.dir = 4'd0;
    bus.goal = 4'd0;
    bus.load_en = 1'b0;
    bus.load_matrix = '0;
    repeat (3) @(negedge clk);
    check("reset_gmatrix", bus.gmatrix == '0, bus.gmatrix, 64'd0);
    check("reset_score", bus.score == 12'd0, 64'(bus.score), 64'd0);
    check("reset_draw", bus.draw_state == 2'd0, 64'(bus.draw_state), 64'd0);
    check("reset_busy", bus.busy == 1'b1, 64'(bus.busy), 64'd1);

    reset = 1'b1;
    wait_busy(40, 4'd0, n);
    check("init_latency", n >= 4 && n <= 34, 64'(n), 64'd34);
    check("init_tiles", fresh_ok(bus.gmatrix), bus.gmatrix, 64'd2);
    check("init_score", bus.score == 12'd0, 64'(bus.score), 64'd0);
    check("init_draw", bus.draw_state == 2'd0, 64'(bus.draw_state), 64'd0);

    score_exp = 0;
    for (int i = 0; i < 12; i++) begin
      do_load(vecs[i].load_m);
      wait_busy(10, 4'd0, n);
      bus.dir = vecs[i].dir;
      @(negedge clk);
      bus.dir = 4'd0;
      wait_busy(40, opp(vecs[i].dir), n);
      @(negedge clk);
      score_exp = (score_exp + vecs[i].pts > 4095) ? 4095 : score_exp + vecs[i].pts;
      check($sformatf("vec%0d_board", i), spawn_ok(bus.gmatrix, vecs[i].exp_m, vecs[i].spawn),
            bus.gmatrix, vecs[i].exp_m);
      check($sformatf("vec%0d_score", i), int'(bus.score) == score_exp, 64'(bus.score),
            64'(score_exp));
      check($sformatf("vec%0d_draw", i), bus.draw_state == 2'd0, 64'(bus.draw_state), 64'd0);
      check($sformatf("vec%0d_busy_len", i),
            (vecs[i].spawn ? (n >= 6 && n <= 21) : (n == 5)) && !bus.busy, 64'(n),
            vecs[i].spawn ? 64'd21 : 64'd5);
    end

    bus.goal = 4'd3;
    do_load(64'h2200_0000_0000_0000);
    wait_busy(10, 4'd0, n);
    bus.dir = LEFT;
    @(negedge clk);
    bus.dir = 4'd0;
    wait_busy(40, 4'd0, n);
    check("win_board", spawn_ok(bus.gmatrix, 64'h3000_0000_0000_0000, 1'b1), bus.gmatrix,
          64'h3000_0000_0000_0000);
    check("win_draw", bus.draw_state == 2'd1, 64'(bus.draw_state), 64'd1);
    snap = bus.gmatrix;
    bus.dir = RIGHT;
    @(negedge clk);
    bus.dir = 4'd0;
    repeat (3) @(negedge clk);
    check("won_ignores_dir", bus.gmatrix == snap && !bus.busy && bus.draw_state == 2'd1,
          bus.gmatrix, snap);

    bus.restart = 1'b1;
    @(negedge clk);
    bus.restart = 1'b0;
    bus.goal = 4'd0;
    wait_busy(40, 4'd0, n);
    check("restart_latency", n >= 4 && n <= 34, 64'(n), 64'd34);
    check("restart_tiles", fresh_ok(bus.gmatrix), bus.gmatrix, 64'd2);
    check("restart_score", bus.score == 12'd0, 64'(bus.score), 64'd0);
    check("restart_draw", bus.draw_state == 2'd0, 64'(bus.draw_state), 64'd0);

    do_load(64'h1212_2121_1212_2121);
    check("lose_check_busy", bus.busy == 1'b1, 64'(bus.busy), 64'd1);
    @(negedge clk);
    check("lose_draw", bus.draw_state == 2'd2 && !bus.busy, 64'(bus.draw_state), 64'd2);
    bus.dir = UP;
    @(negedge clk);
    bus.dir = 4'd0;
    repeat (2) @(negedge clk);
    check("lost_ignores_dir", bus.gmatrix == 64'h1212_2121_1212_2121 && bus.draw_state == 2'd2,
          bus.gmatrix, 64'h1212_2121_1212_2121);

    do_load(64'h1122_0000_0000_0000);
    wait_busy(10, 4'd0, n);
    check("reload_draw", bus.draw_state == 2'd0, 64'(bus.draw_state), 64'd0);
    bus.dir = LEFT;
    @(negedge clk);
    bus.dir = 4'd0;
    @(negedge clk);
    check("move_partial_score", bus.score == 12'd12, 64'(bus.score), 64'd12);
    #2 reset = 1'b0;
    #1;
    check("async_reset_board", bus.gmatrix == '0, bus.gmatrix, 64'd0);
    check("async_reset_score", bus.score == 12'd0 && bus.busy && bus.draw_state == 2'd0,
          64'(bus.score), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
